sorted_run_packer: RTL

- Sits directly downstream of the merge sorter tree and consumes its sorted record stream (one DATW-bit record per cycle, strobed by a data-enable).
- Packs 2^P_LOG consecutive records into one wide word for the memory write path.
- Buffers packed words in a small FIFO behind a valid/ready handshake.
- The tree output cannot be stalled, so the block flags buffer overflow. It also checks that keys within each run are non-decreasing.

---
 rtl/sorted_run_packer_if.sv | 16 +
 rtl/sorted_run_packer.sv | 108 ++++++++++
 2 files changed

// File: rtl/sorted_run_packer_if.sv
// Record-in / packed-word-out bus of the sorted run packer.
// The master drives records and consumer ready; the slave returns the FIFO head.
interface sorted_run_packer_if #(
    parameter int P_LOG = 3,
    parameter int DATW  = 64
);
    logic [DATW-1:0]          din;
    logic                     dinen;
    logic                     flush;
    logic [(DATW<<P_LOG)-1:0] dot;
    logic                     doten;
    logic                     ordy;

    modport master (output din, dinen, flush, ordy, input dot, doten);
    modport slave  (input din, dinen, flush, ordy, output dot, doten);
endinterface

// File: rtl/sorted_run_packer.sv
// Packs 2^P_LOG sorted records into wide words, buffers them in a small FIFO,
// and flags FIFO overflow and any key decrease within a run.
module sorted_run_packer_lane #(
    parameter int DATW = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr,
    input  logic            held,
    input  logic [DATW-1:0] din,
    output logic [DATW-1:0] lane
);
    logic [DATW-1:0] q;

    always_ff @(posedge CLK) begin
        if (RST)     q <= '0;
        else if (wr) q <= din;
    end

    // A lane the run never reached is padded with all-ones.
    assign lane = wr ? din : (held ? q : '1);
endmodule

module sorted_run_packer #(
    parameter int P_LOG    = 3,
    parameter int DATW     = 64,
    parameter int KEYW     = 32,
    parameter int FIFO_LOG = 2
) (
    input  logic                CLK,
    input  logic                RST,
    sorted_run_packer_if.slave  bus,
    output logic [31:0]         cnt,
    output logic                ovf,
    output logic                err,
    output logic                idle
);
    localparam int LANES = 1 << P_LOG;
    localparam int DEPTH = 1 << FIFO_LOG;
    localparam int WW    = DATW * LANES;

    logic [P_LOG-1:0]              s;
    logic [LANES-1:0][DATW-1:0]    word;
    logic                          fill_last, push, pop, full, wr_ok;
    logic [FIFO_LOG:0]             wp, rp;
    logic [WW-1:0]                 mem [DEPTH];
    logic [KEYW-1:0]               prev_key;
    logic                          has_prev;
    logic [KEYW-1:0]               key;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sorted_run_packer_lane #(.DATW(DATW)) u_lane (
            .CLK  (CLK),
            .RST  (RST),
            .wr   (bus.dinen && (s == P_LOG'(k))),
            .held (s > P_LOG'(k)),
            .din  (bus.din),
            .lane (word[k])
        );
    end

    assign key       = bus.din[KEYW-1:0];
    assign fill_last = bus.dinen && (s == P_LOG'(LANES - 1));
    // Flush only pushes if something is in the word; a flush on the filling
    // record folds into the normal push.
    assign push      = fill_last || (bus.flush && ((s != '0) || bus.dinen));

    assign bus.doten = (wp != rp);
    assign full      = (wp[FIFO_LOG] != rp[FIFO_LOG]) &&
                       (wp[FIFO_LOG-1:0] == rp[FIFO_LOG-1:0]);
    assign pop       = bus.doten && bus.ordy;
    assign wr_ok     = push && (!full || pop);
    assign bus.dot   = bus.doten ? mem[rp[FIFO_LOG-1:0]] : '0;
    assign idle      = !bus.doten && (s == '0);

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wp[FIFO_LOG-1:0]] <= word;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s        <= '0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            prev_key <= '0;
            has_prev <= 1'b0;
        end else begin
            if (push)           s <= '0;
            else if (bus.dinen) s <= s + 1'b1;

            if (wr_ok)              wp  <= wp + 1'b1;
            if (pop)                rp  <= rp + 1'b1;
            if (push && full && !pop) ovf <= 1'b1;

            if (bus.dinen) begin
                cnt      <= cnt + 1'b1;
                prev_key <= key;
                if (has_prev && (key < prev_key)) err <= 1'b1;
            end
            // A record arriving with flush is checked, then the run closes.
            if (bus.flush)      has_prev <= 1'b0;
            else if (bus.dinen) has_prev <= 1'b1;
        end
    end
endmodule
